us_ping_scheduler: RTL and testbench

- Round-robin scheduler for up to NUM_SENSORS ultrasonic ping front ends sharing one acoustic space.
- Fires exactly one sensor at a time, waits for its done or a timeout, then enforces a guard gap so echoes do not cross-talk.
- Latches each sensor's distance into a result bank that navigation logic reads by index.
- Sits between the per-sensor ping front ends and the navigation datapath.

---
 rtl/us_ping_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_us_ping_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/us_ping_scheduler.sv
// Round-robin ultrasonic ping scheduler: fires one front end at a time, waits for done/timeout,
// enforces a guard gap and keeps a per-channel result bank. Optional feature macro: US_SCHED_AVG_EN.
module us_ping_scheduler #(
  parameter int unsigned NUM_SENSORS    = 4,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned DIST_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned GUARD_CYCLES   = 500000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [NUM_SENSORS-1:0]        sensor_mask,
  output logic [NUM_SENSORS-1:0]        start,
  input  logic [NUM_SENSORS-1:0]        done,
  input  logic [NUM_SENSORS*DIST_W-1:0] dist_in,
  input  logic [SEL_W-1:0]              rd_sel,
  input  logic                          rd_en,
  output logic [DIST_W-1:0]             rd_dist,
  output logic [NUM_SENSORS-1:0]        valid,
  output logic [NUM_SENSORS-1:0]        timeout,
  output logic                          sweep_done,
  output logic                          busy,
  output logic [SEL_W-1:0]              cur_sensor
);

  localparam int unsigned MAX_CYC = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);
  localparam logic [TIMER_W-1:0] WAIT_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GUARD_LAST = TIMER_W'(GUARD_CYCLES);
  localparam logic [SEL_W-1:0]   PTR_RST    = SEL_W'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_FIRE, S_WAIT, S_GUARD} state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [NUM_SENSORS-1:0] mask_q, mask_d;
  logic [NUM_SENSORS-1:0] start_q, start_d;
  logic [NUM_SENSORS-1:0] valid_q, valid_d;
  logic [NUM_SENSORS-1:0] timeout_q, timeout_d;
  logic                   sweep_done_q, sweep_done_d;
  logic                   busy_q, busy_d;
  logic [DIST_W-1:0]      dist_q [NUM_SENSORS];
  logic [DIST_W-1:0]      dist_d [NUM_SENSORS];
  logic [DIST_W-1:0]      meas;
  logic                   found;
  logic [SEL_W-1:0]       next_idx, top_idx, cand;
`ifdef US_SCHED_AVG_EN
  logic [NUM_SENSORS-1:0] hist_q, hist_d;
  logic [DIST_W:0]        sum;
`endif

  assign meas = dist_in[32'(ptr_q) * DIST_W +: DIST_W];

  // Next enabled channel after ptr (wrapping), and highest channel of the captured mask.
  always_comb begin
    found    = 1'b0;
    next_idx = ptr_q;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_SENSORS; k++) begin
      cand = SEL_W'((32'(ptr_q) + k) % NUM_SENSORS);
      if (!found && sensor_mask[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
    top_idx = '0;
    for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
      if (mask_q[SEL_W'(k)]) top_idx = SEL_W'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    timer_d      = '0;
    mask_d       = mask_q;
    start_d      = '0;
    sweep_done_d = 1'b0;
    valid_d      = valid_q;
    timeout_d    = timeout_q;
    dist_d       = dist_q;
`ifdef US_SCHED_AVG_EN
    hist_d       = hist_q;
    sum          = {1'b0, dist_q[ptr_q]} + {1'b0, meas};
`endif
    // Read clear first so a same-cycle result write below takes precedence.
    if (rd_en) valid_d[rd_sel] = 1'b0;

    unique case (state_q)
      S_IDLE: if (run) state_d = S_SELECT;
      S_SELECT: begin
        mask_d = sensor_mask;
        if (found) begin
          ptr_d            = next_idx;
          start_d[next_idx] = 1'b1;
          state_d          = S_FIRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FIRE: state_d = S_WAIT;
      S_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (done[ptr_q]) begin
          dist_d[ptr_q] = meas;
`ifdef US_SCHED_AVG_EN
          if (hist_q[ptr_q]) dist_d[ptr_q] = DIST_W'(sum >> 1);
          hist_d[ptr_q] = 1'b1;
`endif
          valid_d[ptr_q]   = 1'b1;
          timeout_d[ptr_q] = 1'b0;
          timer_d          = '0;
          state_d          = S_GUARD;
        end else if (timer_q == WAIT_LAST) begin
          dist_d[ptr_q]    = '1;
`ifdef US_SCHED_AVG_EN
          hist_d[ptr_q]    = 1'b0;
`endif
          valid_d[ptr_q]   = 1'b1;
          timeout_d[ptr_q] = 1'b1;
          timer_d          = '0;
          state_d          = S_GUARD;
        end
      end
      S_GUARD: begin
        timer_d = timer_q + TIMER_W'(1);
        if (timer_q == GUARD_LAST) begin
          timer_d      = '0;
          sweep_done_d = (ptr_q == top_idx);
          state_d      = run ? S_SELECT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= PTR_RST;
      timer_q      <= '0;
      mask_q       <= '0;
      start_q      <= '0;
      valid_q      <= '0;
      timeout_q    <= '0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
      dist_q       <= '{default: '0};
`ifdef US_SCHED_AVG_EN
      hist_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      mask_q       <= mask_d;
      start_q      <= start_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      sweep_done_q <= sweep_done_d;
      busy_q       <= busy_d;
      dist_q       <= dist_d;
`ifdef US_SCHED_AVG_EN
      hist_q       <= hist_d;
`endif
    end
  end

  assign start      = start_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign sweep_done = sweep_done_q;
  assign busy       = busy_q;
  assign cur_sensor = ptr_q;
  assign rd_dist    = dist_q[rd_sel];

endmodule

// File: tb/tb_us_ping_scheduler.sv
// Self-checking bench for us_ping_scheduler: directed phases plus randomized measurements
// checked against a behavioural model of the sweep order, timing and result bank.
`timescale 1ns/1ps
module tb_us_ping_scheduler;
  localparam int N      = 4;
  localparam int SW     = 2;
  localparam int DW     = 10;
  localparam int T      = 300;
  localparam int G      = 40;
  localparam int BUDGET = 2000;

  logic            clk = 1'b0;
  logic            reset, run, rd_en;
  logic [N-1:0]    sensor_mask, start, done, valid, timeout;
  logic [N*DW-1:0] dist_in;
  logic [SW-1:0]   rd_sel, cur_sensor;
  logic [DW-1:0]   rd_dist;
  logic            sweep_done, busy;

  us_ping_scheduler #(
    .NUM_SENSORS(N), .SEL_W(SW), .DIST_W(DW), .TIMEOUT_CYCLES(T), .GUARD_CYCLES(G)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .sensor_mask(sensor_mask), .start(start),
    .done(done), .dist_in(dist_in), .rd_sel(rd_sel), .rd_en(rd_en), .rd_dist(rd_dist),
    .valid(valid), .timeout(timeout), .sweep_done(sweep_done), .busy(busy),
    .cur_sensor(cur_sensor)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sweep_seen = 0;
  always @(negedge clk) if (sweep_done === 1'b1) sweep_seen <= sweep_seen + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DW-1:0] m_dist [N];
  logic [N-1:0]  m_valid, m_to, m_has;
  int            m_ptr;
  int            exp_start;
  bit            exp_known;
  int            exp_sweeps = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_ch(input int p, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction

  function automatic int top_ch(input logic [N-1:0] m);
    int t = -1;
    for (int i = 0; i < N; i++) if (m[i]) t = i;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dist[i] = '0;
    m_valid   = '0;
    m_to      = '0;
    m_has     = '0;
    m_ptr     = N - 1;
    exp_known = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, valid, m_valid);
    chk({tag, "_timeout"}, timeout, m_to);
    for (int i = 0; i < N; i++) begin
      rd_sel = SW'(i);
      #1;
      chk($sformatf("%s_dist%0d", tag, i), rd_dist, m_dist[i]);
    end
  endtask

  // One measurement: wait for start, play the front end, then follow the guard to its end.
  task automatic do_meas(input int d, input bit give_done, input logic [DW-1:0] dval,
                         input int stray, input logic [N-1:0] clr, input bit rd_same,
                         input bit drop_run);
    int waited = 0;
    int ch, s, eff, sum;
    logic [N-1:0] cap, onehot;
    ch  = next_ch(m_ptr, sensor_mask);
    cap = sensor_mask;
    while (start === '0 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    chk("start_seen", waited < BUDGET, 1'b1);
    if (waited >= BUDGET) return;
    onehot     = '0;
    onehot[ch] = 1'b1;
    s          = cyc;
    chk("start_onehot", start, onehot);
    if (exp_known) chk("start_cycle", s, exp_start);
    chk("cur_sensor", cur_sensor, ch);
    chk("busy_fire", busy, 1'b1);
    m_ptr = ch;
    @(negedge clk);
    chk("start_width", start, '0);

    if (drop_run) run = 1'b0;
    if (stray >= 0 && stray != ch) begin
      done[stray] = 1'b1;
      dist_in[stray*DW +: DW] = 10'h155;
      @(negedge clk);
      done[stray] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (clr[i]) begin
        rd_sel = SW'(i);
        rd_en  = 1'b1;
        @(negedge clk);
        rd_en      = 1'b0;
        m_valid[i] = 1'b0;
      end
    end

    if (give_done) begin
      while (cyc < s + d) @(negedge clk);
      dist_in[ch*DW +: DW] = dval;
      done[ch] = 1'b1;
      if (rd_same) begin
        rd_sel = SW'(ch);
        rd_en  = 1'b1;
      end
      @(negedge clk);
      done[ch] = 1'b0;
      rd_en    = 1'b0;
      eff      = d;
`ifdef US_SCHED_AVG_EN
      sum = int'(m_dist[ch]) + int'(dval);
      m_dist[ch] = m_has[ch] ? DW'(sum / 2) : dval;
`else
      sum = 0;
      m_dist[ch] = dval;
`endif
      m_has[ch] = 1'b1;
      m_to[ch]  = 1'b0;
    end else begin
      eff = T;
      while (cyc < s + T + 1) @(negedge clk);
      m_dist[ch] = '1;
      m_has[ch]  = 1'b0;
      m_to[ch]   = 1'b1;
    end
    m_valid[ch] = 1'b1;
    check_all($sformatf("res_ch%0d", ch));

    while (cyc < s + eff + G + 1) @(negedge clk);
    chk("sweep_early", sweep_done, 1'b0);
    @(negedge clk);
    chk("sweep_done", sweep_done, ch == top_ch(cap));
    if (ch == top_ch(cap)) exp_sweeps++;
    chk("busy_after_guard", busy, run);
    exp_start = s + eff + G + 3;
    exp_known = run;
  endtask

  initial begin
    int busy_hi, start_hits;
    logic [SW-1:0] held;
    reset = 1'b1; run = 1'b0; sensor_mask = '0; done = '0; dist_in = '0;
    rd_en = 1'b0; rd_sel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_start", start, '0);
    chk("rst_sweep", sweep_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cur", cur_sensor, N - 1);
    check_all("rst");
    reset = 1'b0;

    // Full sweep with fixed distances; stray done[3] while channel 0 is measuring
    sensor_mask = 4'b1111;
    @(negedge clk);
    run = 1'b1;
    exp_start = cyc + 2;
    exp_known = 1'b1;
    do_meas(100, 1, 10'd10, 3, '0, 0, 0);
    do_meas(100, 1, 10'd20, -1, '0, 0, 0);
    do_meas(100, 1, 10'd30, -1, '0, 0, 0);
    do_meas(100, 1, 10'd40, -1, '0, 0, 0);

    // Sparse mask: only 0 and 2; clear old results of 1 and 3 first
    sensor_mask = 4'b0101;
    do_meas(60, 1, 10'd111, -1, 4'b1010, 0, 0);
    do_meas(70, 1, 10'd222, -1, '0, 0, 0);
    do_meas(80, 1, 10'd333, -1, '0, 0, 0);
    do_meas(90, 1, 10'd444, -1, '0, 0, 0);

    // Timeout on channel 1, done exactly on the last WAIT cycle on channel 0
    sensor_mask = 4'b1111;
    do_meas(50, 1, 10'd55, -1, '0, 0, 0);
    do_meas(T, 1, 10'h2AB, -1, '0, 0, 0);
    do_meas(0, 0, '0, -1, '0, 0, 0);
    do_meas(40, 1, 10'd66, -1, '0, 0, 0);
    do_meas(40, 1, 10'd67, -1, '0, 0, 0);
    do_meas(40, 1, 10'd68, -1, '0, 0, 0);
    do_meas(40, 1, 10'd77, -1, '0, 0, 0);

    // run dropped during channel 2's WAIT, then resumed
    do_meas(120, 1, 10'd500, -1, '0, 0, 1);
    busy_hi = 0; start_hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) busy_hi++;
      if (start !== '0) start_hits++;
    end
    chk("paused_busy", busy_hi, 0);
    chk("paused_start", start_hits, 0);
    run = 1'b1;
    exp_start = cyc + 2;
    exp_known = 1'b1;
    do_meas(30, 1, 10'd600, -1, '0, 1, 0);
    do_meas(30, 1, 10'd601, -1, '0, 0, 0);

    // Single channel: timeout, then 100, then 200
    sensor_mask = 4'b0001;
    do_meas(0, 0, '0, -1, '0, 0, 0);
    do_meas(25, 1, 10'd100, -1, '0, 0, 0);
    do_meas(25, 1, 10'd200, -1, '0, 0, 0);

    // Randomized measurements
    for (int it = 0; it < 20; it++) begin
      int stray;
      sensor_mask = N'($urandom_range(1, (1 << N) - 1));
      stray = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      do_meas(int'($urandom_range(8, T)), $urandom_range(0, 5) != 0,
              DW'($urandom), stray, N'($urandom), $urandom_range(0, 3) == 0, 0);
    end

    // Empty mask: IDLE/SELECT cycling, never a start
    sensor_mask = '0;
    held = SW'(m_ptr);
    busy_hi = 0; start_hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) busy_hi++;
      if (start !== '0) start_hits++;
    end
    chk("mask0_start", start_hits, 0);
    chk("mask0_busy_toggles", busy_hi >= 15 && busy_hi <= 25, 1'b1);
    chk("mask0_cur", cur_sensor, held);

    // Reset asserted in SELECT suppresses the start that would follow
    run = 1'b0;
    repeat (3) @(negedge clk);
    sensor_mask = 4'b1111;
    run = 1'b1;
    exp_start = cyc + 2;
    exp_known = 1'b1;
    do_meas(30, 1, 10'd321, -1, '0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_start", start, '0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_sweep", sweep_done, 1'b0);
    chk("rst2_cur", cur_sensor, N - 1);
    model_reset();
    check_all("rst2");
    run = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    run = 1'b1;
    exp_start = cyc + 2;
    exp_known = 1'b1;
    do_meas(20, 1, 10'd123, -1, '0, 0, 0);
    run = 1'b0;
    repeat (3) @(negedge clk);

    chk("sweep_count", sweep_seen, exp_sweeps);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
